// File: rtl/ex_pipe_reg.sv
// Handshaked pipeline stage register (decode -> execute) with flush and stall-vector bubbles.
// Define EX_PIPE_SKID_EN for the two-entry skid build with registered in_ready; default is head-only.
module ex_pipe_reg #(
  parameter int               WIDTH     = 64,
  parameter int               STALL_W   = 6,
  parameter int               STAGE     = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [1:0]         count
);

  logic             r_head_valid;
  logic [WIDTH-1:0] r_head_data;
  logic             w_head_valid_nxt;
  logic [WIDTH-1:0] w_head_data_nxt;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_unused_stall;

  // Only our own two stall bits matter; the rest of the core vector is ignored.
  assign w_unused_stall = ^stall;

  assign w_out_fire = r_head_valid & out_ready & ~stall[STAGE+1];
  assign w_in_fire  = in_valid & in_ready & ~stall[STAGE] & ~flush;

  assign out_valid = r_head_valid;
  assign out_data  = r_head_valid ? r_head_data : NOP_VALUE;

`ifdef EX_PIPE_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic             w_skid_valid_nxt;
  logic [WIDTH-1:0] w_skid_data_nxt;

  // in_fire never coincides with a valid skid, because in_ready is ~skid_valid.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    w_head_valid_nxt = r_head_valid;
    w_head_data_nxt  = r_head_data;
    w_skid_valid_nxt = r_skid_valid;
    w_skid_data_nxt  = r_skid_data;
    if (flush) begin
      w_head_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else begin
      if (w_out_fire) begin
        w_head_valid_nxt = r_skid_valid;
        w_head_data_nxt  = r_skid_data;
        w_skid_valid_nxt = 1'b0;
      end
      if (w_in_fire) begin
        if (w_head_valid_nxt) begin
          w_skid_valid_nxt = 1'b1;
          w_skid_data_nxt  = in_data;
        end else begin
          w_head_valid_nxt = 1'b1;
          w_head_data_nxt  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_head_valid <= w_head_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_skid_data <= w_skid_data_nxt;
  end

  assign in_ready = r_in_ready;
  assign count    = {1'b0, r_head_valid} + {1'b0, r_skid_valid};
`else
  always_comb begin
    w_head_valid_nxt = r_head_valid;
    w_head_data_nxt  = r_head_data;
    if (flush) begin
      w_head_valid_nxt = 1'b0;
    end else begin
      if (w_out_fire) w_head_valid_nxt = 1'b0;
      if (w_in_fire) begin
        w_head_valid_nxt = 1'b1;
        w_head_data_nxt  = in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_head_valid <= 1'b0;
    else     r_head_valid <= w_head_valid_nxt;
  end

  assign in_ready = ~rst & (~r_head_valid | w_out_fire);
  assign count    = {1'b0, r_head_valid};
`endif

  // NOTE: payload storage is not reset; the valid bits alone say whether it means anything.
  always_ff @(posedge clk) begin
    r_head_data <= w_head_data_nxt;
  end

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Scoreboard bench for ex_pipe_reg: a reference FIFO of accepted payloads is compared every cycle.
// Honours EX_PIPE_SKID_EN the same way as the design (capacity and in_ready timing).
module tb_ex_pipe_reg;
  localparam int           W       = 64;
  localparam int           STALL_W = 6;
  localparam int           STAGE   = 2;
  localparam logic [W-1:0] NOP     = 64'hBAD0_0000_0000_0BAD;

  logic               clk = 1'b0;
  logic               rst;
  logic [STALL_W-1:0] stall = '0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic [W-1:0]       in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_ready = 1'b0;
  logic [1:0]         count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] src_q[$];
  logic         armed = 1'b0;
  logic         m_in_fire;
  logic         m_out_fire;

  ex_pipe_reg #(
    .WIDTH(W), .STALL_W(STALL_W), .STAGE(STAGE), .NOP_VALUE(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic cycle(input logic ordy, input logic [STALL_W-1:0] st, input logic fl,
                       input logic r);
    logic exp_ready;
    @(negedge clk);
    rst       = r;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    in_valid  = (src_q.size() != 0);
    if (in_valid) in_data = src_q[0];
    else          in_data = '0;
    #1;
    m_out_fire = (exp_q.size() != 0) && ordy && !st[STAGE+1];
`ifdef EX_PIPE_SKID_EN
    exp_ready = !r && armed && (exp_q.size() < 2);
`else
    exp_ready = !r && ((exp_q.size() == 0) || m_out_fire);
`endif
    m_in_fire = in_valid && exp_ready && !st[STAGE] && !fl;
    check("in_ready", W'(in_ready), W'(exp_ready));
    check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : NOP);
    check("count", W'(count), W'(exp_q.size()));
    @(posedge clk);
    if (!r) begin
      if (fl) exp_q.delete();
      else begin
        if (m_out_fire) void'(exp_q.pop_front());
        if (m_in_fire)  exp_q.push_back(src_q[0]);
      end
      if (m_in_fire) void'(src_q.pop_front());
      armed = 1'b1;
    end
  endtask

  // Called right after a posedge: asserts reset between edges and checks the outputs at once.
  task automatic async_reset();
    #2;
    check("pre_rst_count", W'(count), W'(exp_q.size()));
    rst = 1'b1;
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_count", W'(count), W'(0));
    check("rst_out_data", out_data, NOP);
    check("rst_in_ready", W'(in_ready), W'(0));
    exp_q.delete();
    src_q.delete();
    armed = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    #2 rst = 1'b1;

    // Reset: upstream offer must not be taken
    src_q.push_back(64'h55);
    repeat (2) cycle(1'b1, '0, 1'b0, 1'b1);
    src_q.delete();

    // Stream 0x1..0x8 with out_ready held high
    for (int i = 1; i <= 8; i++) src_q.push_back(W'(i));
    repeat (12) cycle(1'b1, '0, 1'b0, 1'b0);

    // Backpressure A, B, C then release
    src_q.push_back(64'hA); src_q.push_back(64'hB); src_q.push_back(64'hC);
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (6) cycle(1'b1, '0, 1'b0, 1'b0);

    // Bubble: hold 0x5, then upstream stall for 2 cycles
    src_q.push_back(64'h5);
    cycle(1'b0, '0, 1'b0, 1'b0);
    src_q.push_back(64'h6);
    repeat (2) cycle(1'b1, 6'b000100, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, '0, 1'b0, 1'b0);

    // Freeze: downstream stall with out_ready high and head 0x7
    src_q.push_back(64'h7);
    cycle(1'b0, '0, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, 6'b001000, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, '0, 1'b0, 1'b0);

    // Flush collision with a full stage and 0x9 on offer
    src_q.push_back(64'hA2); src_q.push_back(64'hB2);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    src_q.delete();
    src_q.push_back(64'h9);
    cycle(1'b0, '0, 1'b1, 1'b0);
    src_q.delete();
    repeat (3) cycle(1'b1, '0, 1'b0, 1'b0);

    // Async reset between edges with a full stage
    src_q.push_back(64'h11); src_q.push_back(64'h12);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    async_reset();
    src_q.push_back(64'h13);
    repeat (2) cycle(1'b1, '0, 1'b0, 1'b1);

    // Random traffic: backpressure, both stall bits, occasional flush
    for (int i = 0; i < 300; i++) begin
      logic [STALL_W-1:0] st;
      if (src_q.size() < 3 && $urandom_range(0, 2) != 0)
        src_q.push_back({$urandom(), $urandom()});
      st = W'($urandom()) & 6'b110011;
      st[STAGE]   = ($urandom_range(0, 4) == 0);
      st[STAGE+1] = ($urandom_range(0, 4) == 0);
      cycle($urandom_range(0, 3) != 0, st, $urandom_range(0, 19) == 0, 1'b0);
    end

    src_q.delete();
    repeat (4) cycle(1'b1, '0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ex_pipe_reg.md
# ex_pipe_reg

Parametrised, handshaked pipeline stage register: the next generation of the ID→EX boundary register, generalised to an arbitrary payload width. It carries one packed payload bus (opcode, funct fields, operands, destination, write-enable, offset, packed by the instantiating stage) from decode into execute. It adds valid/ready flow control, an optional 2-entry skid buffer, synchronous flush and legacy stall-vector bubble insertion. One instance sits between each pair of core stages.

## Interface
- `WIDTH`, 64: payload width in bits (≥1).
- `STALL_W`, 6: width of the core stall vector.
- `STAGE`, 2: index of the upstream stage in `stall`; `STAGE+1` is the downstream stage (`STAGE+1 < STALL_W`).
- `NOP_VALUE`, `{WIDTH{1'b0}}`: payload presented whenever the stage is empty (bubble).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in `STALL_W`: core stall vector.
- `flush` in 1: synchronous kill of all held entries.
- `in_valid` in 1: upstream payload valid.
- `in_data` in `WIDTH`: upstream payload.
- `in_ready` out 1: stage can accept.
- `out_valid` out 1: head entry valid.
- `out_data` out `WIDTH`: head payload, or `NOP_VALUE` when `out_valid`=0.
- `out_ready` in 1: downstream accepts.
- `count` out 2: entries held (0..2).

## Operation
- Accept: `in_fire = in_valid & in_ready & ~stall[STAGE] & ~flush`.
- Drain: `out_fire = out_valid & out_ready & ~stall[STAGE+1]`.
- Storage has two entries, head and skid.
  - `in_fire` with an empty head, or with a head that drains the same cycle, writes the head.
  - `in_fire` with a head that is full and not draining writes skid.
  - `out_fire` with skid valid moves skid into the head.
- Bubble rule:
  - `stall[STAGE]=1` and `stall[STAGE+1]=0` means no accept; the head drains normally and the downstream sees `out_valid`=0 / `NOP_VALUE` once empty.
  - `stall[STAGE+1]=1` freezes the head and skid regardless of `out_ready`.
- Flush:
  - `flush`=1 at an edge clears head and skid, so `count`=0 and `out_valid`=0 next cycle.
  - `in_data` offered that cycle is dropped.
  - `flush` beats accept, drain and stall.
- Ordering is strict FIFO; no payload is duplicated or lost except by flush or reset.
- `count` = head_valid + skid_valid; the value 3 is unreachable.

## Timing
- Reset (async, immediate): `out_valid`=0, `out_data`=`NOP_VALUE`, `count`=0.
  - `in_ready`=0 while `rst`=1, and becomes 1 on the first edge after release.
- Latency: payload accepted at edge N appears on `out_*` after edge N; zero-bubble throughput is 1 per cycle.
- `in_ready` is registered (`= ~skid_valid`), with no combinational path from `out_ready`.
- Full boundary: `count`=2 gives `in_ready`=0 the next cycle. Simultaneous drain and offer at `count`=2 drains only; the skid moves to the head.
- Empty boundary: `count`=0 with a simultaneous offer and `out_ready` gives no pass-through; data appears next cycle.
- `out_data` changes only on an edge.
- Reset mid-transfer discards all entries, and no partial payload is emitted.

## Configuration
- `EX_PIPE_SKID_EN` defined: two-entry skid buffer as above; `in_ready` is registered.
- `EX_PIPE_SKID_EN` undefined: head only, `count` ≤1.
  - `in_ready = ~rst & (~head_valid | out_fire)`, combinational from `out_ready`/`stall`.
  - Accept, flush, bubble and reset rules are unchanged.

## Test plan
- Reset then stream: release `rst`, drive 0x1..0x8 with `out_ready`=1 → `out_data` 0x1..0x8 on consecutive cycles one edge later; `count` ≤1; `in_ready`=0 during reset.
- Backpressure: `out_ready`=0 while offering 0xA, 0xB, 0xC → `count`=2, `in_ready`=0 with 0xC held upstream. Then `out_ready`=1 → A, B, C emerge in order (skid build); no-skid build gives `count`≤1.
- Bubble: `stall[2]`=1, `stall[3]`=0 for 2 cycles with one entry 0x5 held → 0x5 drains, then `out_valid`=0 and `out_data`=`NOP_VALUE` for the remaining cycle; upstream not accepted.
- Freeze: `stall[3]`=1 with `out_ready`=1 and head 0x7 → `out_data` stays 0x7 and `count` is unchanged until `stall[3]` drops.
- Flush collision: `count`=2, `flush`=1 with `in_valid`=1 and `in_data`=0x9 → next cycle `count`=0, `out_valid`=0; 0x9 never appears.
- Async reset mid-stream: assert `rst` between edges with `count`=2 → `out_valid`=0 and `count`=0 immediately, before the next edge.
